// File: rtl/credit_collision.sv
// Ball/credit overlap detector: accumulates overlaps per frame and reports the first hit at the next frame boundary.
// Optional per-credit cooldown is built when CREDIT_COLLISION_COOLDOWN_EN is defined.
module credit_collision #(
  parameter int NUM_CREDITS     = 8,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       drawBall,
  input  logic       drawCredit,
  input  logic [3:0] creditIndex,
  output logic       collisionBallCredit,
  output logic [3:0] collisionCreditIndex,
  output logic [7:0] collisionCount
);

  typedef enum logic [1:0] {IDLE, PENDING, REPORT} state_t;

  state_t     state;
  logic [3:0] pendIdx;
  logic       newHit;
  logic       overlap;
  logic       hasPend;
  logic       fireOk;

  assign overlap = drawBall && drawCredit && (int'(creditIndex) < NUM_CREDITS);
  // A hit that arrived with the boundary that entered REPORT is still owed a report.
  assign hasPend = (state == PENDING) || (state == REPORT && newHit);

`ifdef CREDIT_COLLISION_COOLDOWN_EN
  logic [NUM_CREDITS-1:0] seenMask;
  logic [NUM_CREDITS-1:0] hitBit;
  logic [3:0]             cd [NUM_CREDITS];
  logic [3:0]             cdPend;

  always_comb begin
    hitBit = '0;
    if (overlap) hitBit = NUM_CREDITS'(1) << creditIndex;
  end

  always_comb begin
    cdPend = '0;
    for (int k = 0; k < NUM_CREDITS; k++)
      if (pendIdx == 4'(k)) cdPend = cd[k];
  end

  assign fireOk = (cdPend == 4'd0);

  // Boundary overlap belongs to the new frame, so its bit replaces the cleared mask.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      seenMask <= '0;
      for (int k = 0; k < NUM_CREDITS; k++) cd[k] <= '0;
    end else if (startOfFrame) begin
      seenMask <= hitBit;
      for (int k = 0; k < NUM_CREDITS; k++) begin
        if (seenMask[k])        cd[k] <= 4'(COOLDOWN_FRAMES);
        else if (cd[k] != 4'd0) cd[k] <= cd[k] - 4'd1;
      end
    end else begin
      seenMask <= seenMask | hitBit;
    end
  end
`else
  assign fireOk = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state                <= IDLE;
      pendIdx              <= '0;
      newHit               <= 1'b0;
      collisionBallCredit  <= 1'b0;
      collisionCreditIndex <= '0;
      collisionCount       <= '0;
    end else begin
      collisionBallCredit <= 1'b0;
      newHit              <= 1'b0;
      if (startOfFrame) begin
        if (hasPend && fireOk) begin
          collisionBallCredit  <= 1'b1;
          collisionCreditIndex <= pendIdx;
          if (collisionCount != 8'hFF) collisionCount <= collisionCount + 8'd1;
        end
        if (overlap) pendIdx <= creditIndex;
        if (hasPend) begin
          state  <= REPORT;
          newHit <= overlap;
        end else begin
          state <= overlap ? PENDING : IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (overlap) begin
              pendIdx <= creditIndex;
              state   <= PENDING;
            end
          end
          PENDING: state <= PENDING;
          REPORT: begin
            if (newHit) begin
              state <= PENDING;
            end else if (overlap) begin
              pendIdx <= creditIndex;
              state   <= PENDING;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_credit_collision.sv
// Directed bench for credit_collision; expectations adapt to CREDIT_COLLISION_COOLDOWN_EN.
module tb_credit_collision;

`ifdef CREDIT_COLLISION_COOLDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       drawBall;
  logic       drawCredit;
  logic [3:0] creditIndex;
  logic       collisionBallCredit;
  logic [3:0] collisionCreditIndex;
  logic [7:0] collisionCount;

  int nVec = 0;
  int nErr = 0;

  credit_collision #(.NUM_CREDITS(8), .COOLDOWN_FRAMES(8)) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .drawBall(drawBall),
    .drawCredit(drawCredit),
    .creditIndex(creditIndex),
    .collisionBallCredit(collisionBallCredit),
    .collisionCreditIndex(collisionCreditIndex),
    .collisionCount(collisionCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic sof, input logic ball, input logic cred, input logic [3:0] idx);
    startOfFrame = sof;
    drawBall     = ball;
    drawCredit   = cred;
    creditIndex  = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    resetN = 1'b1;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    cyc(0, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b0) begin nErr++; $display("FAIL reset_pulse: got %0b expected 0", collisionBallCredit); end
    nVec++; if (collisionCreditIndex !== 4'd0) begin nErr++; $display("FAIL reset_index: got %0d expected 0", collisionCreditIndex); end
    nVec++; if (collisionCount !== 8'd0) begin nErr++; $display("FAIL reset_count: got %0d expected 0", collisionCount); end
    resetN = 1'b1;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_basic();
    doReset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 3);
    cyc(0, 1, 1, 3);
    cyc(0, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b0 || collisionCount !== 8'd0 || collisionCreditIndex !== 4'd0) begin
      nErr++; $display("FAIL basic_early: got pulse=%0b idx=%0d cnt=%0d expected 0/0/0", collisionBallCredit, collisionCreditIndex, collisionCount);
    end
    cyc(1, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b1) begin nErr++; $display("FAIL basic_pulse: got %0b expected 1", collisionBallCredit); end
    nVec++; if (collisionCreditIndex !== 4'd3) begin nErr++; $display("FAIL basic_index: got %0d expected 3", collisionCreditIndex); end
    nVec++; if (collisionCount !== 8'd1) begin nErr++; $display("FAIL basic_count: got %0d expected 1", collisionCount); end
    cyc(0, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b0 || collisionCount !== 8'd1 || collisionCreditIndex !== 4'd3) begin
      nErr++; $display("FAIL basic_after: got pulse=%0b idx=%0d cnt=%0d expected 0/3/1", collisionBallCredit, collisionCreditIndex, collisionCount);
    end
  endtask

  task automatic test_first_wins();
    doReset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 5);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 2);
    cyc(1, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b1 || collisionCreditIndex !== 4'd5 || collisionCount !== 8'd1) begin
      nErr++; $display("FAIL first_wins: got pulse=%0b idx=%0d cnt=%0d expected 1/5/1", collisionBallCredit, collisionCreditIndex, collisionCount);
    end
    cyc(0, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b0) begin nErr++; $display("FAIL first_wins_width: got %0b expected 0", collisionBallCredit); end
    cyc(0, 1, 1, 2);
    cyc(1, 0, 0, 0);
    nVec++; if (collisionBallCredit !== !CD_EN || collisionCreditIndex !== (CD_EN ? 4'd5 : 4'd2) || collisionCount !== (CD_EN ? 8'd1 : 8'd2)) begin
      nErr++; $display("FAIL second_armed: got pulse=%0b idx=%0d cnt=%0d expected %0b/%0d/%0d", collisionBallCredit,
                       collisionCreditIndex, collisionCount, !CD_EN, CD_EN ? 5 : 2, CD_EN ? 1 : 2);
    end
  endtask

  task automatic test_cooldown();
    logic expP;
    doReset();
    cyc(1, 0, 0, 0);
    for (int f = 1; f <= 13; f++) begin
      if (f <= 4 || f == 13) cyc(0, 1, 1, 1);
      else cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      expP = (f == 1 || f == 13 || (!CD_EN && f <= 4));
      nVec++; if (collisionBallCredit !== expP) begin
        nErr++; $display("FAIL cooldown_frame%0d: got %0b expected %0b", f, collisionBallCredit, expP);
      end
    end
    nVec++; if (collisionCount !== (CD_EN ? 8'd2 : 8'd5)) begin
      nErr++; $display("FAIL cooldown_count: got %0d expected %0d", collisionCount, CD_EN ? 2 : 5);
    end
  endtask

  task automatic test_ignored();
    doReset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 9);
    cyc(0, 0, 1, 2);
    cyc(0, 1, 0, 2);
    cyc(1, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b0 || collisionCount !== 8'd0) begin
      nErr++; $display("FAIL ignored: got pulse=%0b cnt=%0d expected 0/0", collisionBallCredit, collisionCount);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b0) begin nErr++; $display("FAIL ignored_next: got %0b expected 0", collisionBallCredit); end
  endtask

  task automatic test_same_cycle();
    doReset();
    cyc(1, 1, 1, 4);
    nVec++; if (collisionBallCredit !== 1'b0) begin nErr++; $display("FAIL same_cycle_now: got %0b expected 0", collisionBallCredit); end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b1 || collisionCreditIndex !== 4'd4 || collisionCount !== 8'd1) begin
      nErr++; $display("FAIL same_cycle_next: got pulse=%0b idx=%0d cnt=%0d expected 1/4/1", collisionBallCredit, collisionCreditIndex, collisionCount);
    end
    cyc(0, 1, 1, 4);
    cyc(1, 0, 0, 0);
    nVec++; if (collisionBallCredit !== !CD_EN) begin
      nErr++; $display("FAIL same_cycle_mask: got %0b expected %0b", collisionBallCredit, !CD_EN);
    end
    // Reset dropped while a hit is pending.
    cyc(0, 1, 1, 6);
    resetN = 1'b0;
    #1;
    nVec++; if (collisionBallCredit !== 1'b0 || collisionCreditIndex !== 4'd0 || collisionCount !== 8'd0) begin
      nErr++; $display("FAIL midreset: got pulse=%0b idx=%0d cnt=%0d expected 0/0/0", collisionBallCredit, collisionCreditIndex, collisionCount);
    end
    cyc(0, 0, 0, 0);
    resetN = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    nVec++; if (collisionBallCredit !== 1'b0 || collisionCount !== 8'd0) begin
      nErr++; $display("FAIL midreset_lost: got pulse=%0b cnt=%0d expected 0/0", collisionBallCredit, collisionCount);
    end
  endtask

  task automatic test_saturation();
    doReset();
    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 300; i++) begin
      cyc(0, 1, 1, 0);
      cyc(1, 0, 0, 0);
      if (i == 100 || i == 255 || i == 300) begin
        nVec++; if (collisionBallCredit !== 1'b1) begin nErr++; $display("FAIL sat_pulse%0d: got %0b expected 1", i, collisionBallCredit); end
        nVec++; if (collisionCount !== ((i > 255) ? 8'd255 : 8'(i))) begin
          nErr++; $display("FAIL sat_count%0d: got %0d expected %0d", i, collisionCount, (i > 255) ? 255 : i);
        end
      end
      for (int j = 0; j < 8; j++) cyc(1, 0, 0, 0);
    end
    nVec++; if (collisionCount !== 8'd255) begin nErr++; $display("FAIL sat_hold: got %0d expected 255", collisionCount); end
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    drawBall     = 1'b0;
    drawCredit   = 1'b0;
    creditIndex  = 4'd0;
    test_reset();
    test_basic();
    test_first_wins();
    test_cooldown();
    test_ignored();
    test_same_cycle();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/credit_collision.md
# credit_collision

Detects overlap between the ball and the main-screen credit circles and produces the single-cycle, frame-aligned `collisionBallCredit` event consumed by the credit display/control logic. Overlaps are accumulated pixel by pixel during a frame and reported once, at the next frame boundary, together with the index of the credit hit. A per-credit cooldown prevents a ball resting on a credit from re-triggering it every frame. The block sits between the drawing layer and the credit display/control path, alongside the other collision detectors.

## Interface
Parameters:
- `NUM_CREDITS`, default 8: number of credit objects; valid indices are 0..NUM_CREDITS-1, with NUM_CREDITS ≤ 16.
- `COOLDOWN_FRAMES`, default 8: number of overlap-free frames required before the same credit can report again. Range 1..15.

Ports:
- `clk`  in  1: pixel clock.
- `resetN`  in  1: asynchronous, active-low reset.
- `startOfFrame`  in  1: one-cycle strobe marking the first pixel of a new frame.
- `drawBall`  in  1: the ball covers the current pixel.
- `drawCredit`  in  1: a credit (circle or number) covers the current pixel.
- `creditIndex`  in  4: index of the credit covering the current pixel. Valid only when `drawCredit` is high.
- `collisionBallCredit`  out  1: one-cycle collision event.
- `collisionCreditIndex`  out  4: index of the credit that was hit. Updated only when a pulse fires; held otherwise.
- `collisionCount`  out  8: total number of pulses emitted since reset. Saturates at 255.

## Operation
- A pixel overlap is `drawBall && drawCredit && creditIndex < NUM_CREDITS`. Overlaps with an out-of-range index are ignored.
- States:
  - IDLE: no overlap latched this frame. On the first overlap pixel, latch `creditIndex` into `pendIdx`, set bit `creditIndex` in `seenMask`, and go to PENDING.
  - PENDING: `pendIdx` is frozen; the first overlap in raster order wins. Every further overlap pixel sets its bit in `seenMask`.
  - REPORT: entered for exactly one cycle after `startOfFrame` from PENDING. Drives the pulse if it is allowed, then returns to IDLE.
- On `startOfFrame` (any state), the following happen in the same edge:
  - Each credit's cooldown counter `cd[k]` is reloaded to COOLDOWN_FRAMES if `seenMask[k]` is set. Otherwise it is decremented if nonzero.
  - `seenMask` is cleared.
  - The fire decision uses the `cd[pendIdx]` value from before the update. The pulse is allowed only if that value is 0.
- If `startOfFrame` and an overlap pixel arrive in the same cycle, the overlap belongs to the new frame:
  - It is latched as the first hit of the new frame.
  - Its `seenMask` bit survives the clear.
- When the pulse fires, `collisionCreditIndex` is set to `pendIdx` and `collisionCount` is incremented, saturating at 255.
- A PENDING hit whose cooldown is nonzero is dropped silently. No pulse is emitted, and the index and count outputs do not change.
- At most one pulse is emitted per frame. A second credit hit in the same frame is not reported, but its cooldown is still armed.

## Timing
- Reset values: `collisionBallCredit`=0, `collisionCreditIndex`=0, `collisionCount`=0, state IDLE, `pendIdx`=0, `seenMask`=0, all `cd[k]`=0.
- Latency: the pulse is high in the clock cycle immediately after the cycle in which `startOfFrame` is sampled high. It lasts exactly 1 cycle.
- `collisionCreditIndex` and `collisionCount` change on the same edge that raises the pulse. They are stable whenever the pulse is high.
- Reset asserted mid-frame or during REPORT clears everything immediately. Any pending hit is lost and no pulse is emitted.
- If `startOfFrame` arrives while in REPORT, it is handled as a normal frame boundary on that edge. This case cannot occur in normal operation.

## Configuration
- `CREDIT_COLLISION_COOLDOWN_EN` defined:
  - The cooldown counters and `seenMask` are built.
  - Behaviour is as described above.
- Not defined:
  - No cooldown counters and no `seenMask` are built.
  - Every frame with a latched hit fires a pulse, so a ball resting on a credit reports once per frame.
  - `COOLDOWN_FRAMES` is ignored.

## Test plan
- After reset, frame 1 has ball/credit overlap pixels with `creditIndex`=3 → one cycle after the next `startOfFrame`: pulse=1 for 1 cycle, index=3, count=1. The outputs do not change before that.
- Frame 1 overlaps credit 5 first in raster order and credit 2 later → a single pulse with index=5. Cooldown is armed for both credits: an overlap on credit 2 in frame 2 produces no pulse.
- Cooldown enabled, `COOLDOWN_FRAMES`=8, ball overlaps credit 1 in frames 1–4 and is clear in frames 5–12, then overlaps again in frame 13 → pulses only after frames 1 and 13, count=2. With the macro undefined → pulses after frames 1–4 and 13, count=5.
- Overlap with `drawCredit`=1, `creditIndex`=9, `NUM_CREDITS`=8 → no pulse, count unchanged. Overlap with `drawBall`=0 → no pulse.
- Overlap pixel in the same cycle as `startOfFrame` → no pulse at this boundary; a pulse fires after the following `startOfFrame`. Then `resetN` is dropped during a PENDING frame → all outputs are 0 and no pulse follows.
- 300 separate qualifying hits spaced beyond the cooldown → `collisionCount` saturates and holds at 255.
